tick_prescaler: RTL and testbench

Programmable tick generator that sits directly upstream of the countdown timer. It divides the system clock by a run-time divider and drives the timer's `timer_tick` input with single-cycle pulses. It runs either continuously or for a fixed burst of ticks. Start, abort and phase-resync controls let software align the tick stream to the timer's `start` event.

---
 rtl/tick_prescaler.sv | 154 +++++++++++++++
 tb/tb_tick_prescaler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tick_prescaler.sv
// Programmable tick prescaler: divides clk by a run-time divider and drives
// single-cycle timer_tick pulses. It runs either continuously or for a fixed
// burst of ticks, with start, abort and phase-resync controls.
module tick_prescaler #(
    parameter int unsigned DIV_W = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sync,
    input  logic [DIV_W-1:0] divider,
    input  logic             mode,
    input  logic [CNT_W-1:0] burst_len,
    output logic             timer_tick,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] tick_count
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               enable_q, enable_d;
    logic [DIV_W-1:0]   pcnt_q, pcnt_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0]   burst_len_q, burst_len_d;
    logic               mode_q, mode_d;
    logic               tick_q, tick_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   tick_count_q, tick_count_d;

    logic [DIV_W-1:0]   reload_c;
    logic               start_c;
    logic               last_tick_c;
    logic [CNT_W-1:0]   tick_count_inc_c;
    logic [CNT_W-1:0]   burst_cnt_inc_c;

    // Reload value D'-1 from the live divider; a zero divider behaves as 1.
    always_comb begin
        reload_c = '0;
        if (divider != '0) begin
            reload_c = divider - DIV_W'(1);
        end
    end

    // Rising edge of enable; only acted upon while idle.
    always_comb begin
        start_c = enable & ~enable_q;
    end

    // Counter helpers: saturating reported count, wrapping internal burst count.
    always_comb begin
        burst_cnt_inc_c  = burst_cnt_q + CNT_W'(1);
        last_tick_c      = mode_q && (burst_cnt_inc_c == burst_len_q);
        tick_count_inc_c = tick_count_q;
        if (tick_count_q != '1) begin
            tick_count_inc_c = tick_count_q + CNT_W'(1);
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        enable_d     = enable;
        pcnt_d       = pcnt_q;
        burst_cnt_d  = burst_cnt_q;
        burst_len_d  = burst_len_q;
        mode_d       = mode_q;
        tick_d       = 1'b0;
        done_d       = 1'b0;
        tick_count_d = tick_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    pcnt_d       = reload_c;
                    tick_count_d = '0;
                    burst_cnt_d  = '0;
                    mode_d       = mode;
                    burst_len_d  = burst_len;
                    if (mode && (burst_len == '0)) begin
                        // Empty burst completes immediately without running.
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    // Abort beats any tick or completion due this edge.
                    state_d = ST_IDLE;
                end else if (sync) begin
                    // Phase restart; a tick due this edge is dropped.
                    pcnt_d = reload_c;
                end else if (pcnt_q == '0) begin
                    tick_d       = 1'b1;
                    pcnt_d       = reload_c;
                    tick_count_d = tick_count_inc_c;
                    burst_cnt_d  = burst_cnt_inc_c;
                    if (last_tick_c) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    pcnt_d = pcnt_q - DIV_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            enable_q     <= 1'b0;
            pcnt_q       <= '0;
            burst_cnt_q  <= '0;
            burst_len_q  <= '0;
            mode_q       <= 1'b0;
            tick_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            tick_count_q <= '0;
        end else begin
            state_q      <= state_d;
            enable_q     <= enable_d;
            pcnt_q       <= pcnt_d;
            burst_cnt_q  <= burst_cnt_d;
            burst_len_q  <= burst_len_d;
            mode_q       <= mode_d;
            tick_q       <= tick_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            tick_count_q <= tick_count_d;
        end
    end

    assign timer_tick = tick_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign tick_count = tick_count_q;

endmodule

// File: tb/tb_tick_prescaler.sv
// Directed, table-driven bench for tick_prescaler.
module tb_tick_prescaler;

    localparam int unsigned DIV_W = 32;
    localparam int unsigned CNT_W = 32;

    logic             clk;
    logic             rst;
    logic             enable;
    logic             sync;
    logic [DIV_W-1:0] divider;
    logic             mode;
    logic [CNT_W-1:0] burst_len;
    logic             timer_tick;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] tick_count;

    typedef struct {
        logic             en;
        logic             sy;
        logic [DIV_W-1:0] div;
        logic             md;
        logic [CNT_W-1:0] blen;
        logic             tick;
        logic             bsy;
        logic             dn;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_applied;
    int   n_miscompares;

    tick_prescaler #(
        .DIV_W(DIV_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .sync      (sync),
        .divider   (divider),
        .mode      (mode),
        .burst_len (burst_len),
        .timer_tick(timer_tick),
        .busy      (busy),
        .done      (done),
        .tick_count(tick_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Append rep identical one-edge vectors.
    function automatic void add(input logic en, input logic sy, input int div,
                                input logic md, input int blen, input logic tick,
                                input logic bsy, input logic dn, input int cnt,
                                input int rep);
        vec_t v;
        v.en   = en;
        v.sy   = sy;
        v.div  = DIV_W'(div);
        v.md   = md;
        v.blen = CNT_W'(blen);
        v.tick = tick;
        v.bsy  = bsy;
        v.dn   = dn;
        v.cnt  = CNT_W'(cnt);
        for (int r = 0; r < rep; r++) vecs.push_back(v);
    endfunction

    task automatic check_out(input string name, input logic tick, input logic bsy,
                             input logic dn, input logic [CNT_W-1:0] cnt);
        n_applied++;
        if (timer_tick !== tick || busy !== bsy || done !== dn || tick_count !== cnt) begin
            n_miscompares++;
            $display("FAIL %s: got tick=%b busy=%b done=%b count=%0d, want tick=%b busy=%b done=%b count=%0d",
                     name, timer_tick, busy, done, tick_count, tick, bsy, dn, cnt);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_applied     = 0;
        n_miscompares = 0;
        rst       = 1'b1;
        enable    = 1'b0;
        sync      = 1'b0;
        divider   = '0;
        mode      = 1'b0;
        burst_len = '0;

        // en sy div md blen | tick busy done cnt | rep
        // Continuous, divider 4, then abort.
        add(0, 0, 4, 0, 0,  0, 0, 0, 0, 3);
        add(1, 0, 4, 0, 0,  0, 1, 0, 0, 4);
        add(1, 0, 4, 0, 0,  1, 1, 0, 1, 1);
        add(1, 0, 4, 0, 0,  0, 1, 0, 1, 3);
        add(1, 0, 4, 0, 0,  1, 1, 0, 2, 1);
        add(1, 0, 4, 0, 0,  0, 1, 0, 2, 3);
        add(1, 0, 4, 0, 0,  1, 1, 0, 3, 1);
        add(0, 0, 4, 0, 0,  0, 0, 0, 3, 2);
        // Burst of 5 with divider 0; enable held high gives no restart.
        add(1, 0, 0, 1, 5,  0, 1, 0, 0, 1);
        add(1, 0, 0, 1, 5,  1, 1, 0, 1, 1);
        add(1, 0, 0, 1, 5,  1, 1, 0, 2, 1);
        add(1, 0, 0, 1, 5,  1, 1, 0, 3, 1);
        add(1, 0, 0, 1, 5,  1, 1, 0, 4, 1);
        add(1, 0, 0, 1, 5,  1, 0, 1, 5, 1);
        add(1, 0, 0, 1, 5,  0, 0, 0, 5, 3);
        add(0, 0, 0, 1, 5,  0, 0, 0, 5, 1);
        // Zero-length burst.
        add(1, 0, 3, 1, 0,  0, 0, 1, 0, 1);
        add(1, 0, 3, 1, 0,  0, 0, 0, 0, 2);
        add(0, 0, 3, 1, 0,  0, 0, 0, 0, 1);
        // Divider 5 with sync before a due tick, then sync on a due tick.
        add(1, 0, 5, 0, 0,  0, 1, 0, 0, 5);
        add(1, 0, 5, 0, 0,  1, 1, 0, 1, 1);
        add(1, 0, 5, 0, 0,  0, 1, 0, 1, 3);
        add(1, 1, 5, 0, 0,  0, 1, 0, 1, 1);
        add(1, 0, 5, 0, 0,  0, 1, 0, 1, 4);
        add(1, 0, 5, 0, 0,  1, 1, 0, 2, 1);
        add(1, 0, 5, 0, 0,  0, 1, 0, 2, 4);
        add(1, 1, 5, 0, 0,  0, 1, 0, 2, 1);
        add(1, 0, 5, 0, 0,  0, 1, 0, 2, 4);
        add(1, 0, 5, 0, 0,  1, 1, 0, 3, 1);
        add(0, 0, 5, 0, 0,  0, 0, 0, 3, 1);
        // Burst of 4 at divider 2, aborted on the edge of the 4th tick.
        add(1, 0, 2, 1, 4,  0, 1, 0, 0, 2);
        add(1, 0, 2, 1, 4,  1, 1, 0, 1, 1);
        add(1, 0, 2, 1, 4,  0, 1, 0, 1, 1);
        add(1, 0, 2, 1, 4,  1, 1, 0, 2, 1);
        add(1, 0, 2, 1, 4,  0, 1, 0, 2, 1);
        add(1, 0, 2, 1, 4,  1, 1, 0, 3, 1);
        add(1, 0, 2, 1, 4,  0, 1, 0, 3, 1);
        add(0, 0, 2, 1, 4,  0, 0, 0, 3, 2);
        // Divider 4 changed to 2 mid-period.
        add(1, 0, 4, 0, 0,  0, 1, 0, 0, 1);
        add(1, 0, 2, 0, 0,  0, 1, 0, 0, 3);
        add(1, 0, 2, 0, 0,  1, 1, 0, 1, 1);
        add(1, 0, 2, 0, 0,  0, 1, 0, 1, 1);
        add(1, 0, 2, 0, 0,  1, 1, 0, 2, 1);
        add(1, 0, 2, 0, 0,  0, 1, 0, 2, 1);
        add(1, 0, 2, 0, 0,  1, 1, 0, 3, 1);

        // Reset state.
        step();
        check_out("reset", 1'b0, 1'b0, 1'b0, '0);
        step();
        rst = 1'b0;

        foreach (vecs[i]) begin
            enable    = vecs[i].en;
            sync      = vecs[i].sy;
            divider   = vecs[i].div;
            mode      = vecs[i].md;
            burst_len = vecs[i].blen;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].tick, vecs[i].bsy,
                      vecs[i].dn, vecs[i].cnt);
        end

        // Asynchronous reset mid-run: outputs clear before the next edge.
        sync = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", 1'b0, 1'b0, 1'b0, '0);
        step();
        check_out("rst_held", 1'b0, 1'b0, 1'b0, '0);
        rst = 1'b0;

        // Release with enable high: start on the first edge, tick after D'=2.
        step();
        check_out("rst_release_start", 1'b0, 1'b1, 1'b0, '0);
        step();
        check_out("rst_release_p1", 1'b0, 1'b1, 1'b0, '0);
        step();
        check_out("rst_release_tick", 1'b1, 1'b1, 1'b0, CNT_W'(1));

        // Maximum burst length is accepted and keeps running.
        enable = 1'b0;
        step();
        check_out("max_abort", 1'b0, 1'b0, 1'b0, CNT_W'(1));
        enable    = 1'b1;
        divider   = DIV_W'(1);
        mode      = 1'b1;
        burst_len = '1;
        step();
        check_out("max_start", 1'b0, 1'b1, 1'b0, '0);
        for (int c = 1; c <= 3; c++) begin
            step();
            check_out($sformatf("max_tick%0d", c), 1'b1, 1'b1, 1'b0, CNT_W'(c));
        end
        enable = 1'b0;
        step();
        check_out("max_end", 1'b0, 1'b0, 1'b0, CNT_W'(3));

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule
